// File: rtl/neuron_mac_stream.sv
// Single neuron: streams N_IN signed samples through a programmable-weight MAC
// onto a programmable bias with saturation, then emits an activated result.
module neuron_mac_stream #(
  parameter int N_IN     = 3,
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = 12,
  parameter int ACC_W    = 26,
  parameter int ADDR_W   = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ACC_W-1:0]  cfg_wdata,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]           cnt;
  logic signed [WEIGHT_W-1:0] w [N_IN];
  logic signed [ACC_W-1:0]    bias;
  logic signed [ACC_W-1:0]    acc;
  logic                       sat_flag;

  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    sum_sat;
  logic                       ovf;
  logic                       flag_next;
  logic                       accept;
  logic                       last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  // The first sample of a vector adds onto the bias instead of the running sum.
  always_comb begin
    prod      = PROD_W'($signed(in_data)) * PROD_W'(w[cnt]);
    prod_ext  = ACC_W'(prod);
    addend    = (cnt == '0) ? bias : acc;
    sum       = addend + prod_ext;
    ovf       = (addend[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum[ACC_W-1] != addend[ACC_W-1]);
    sum_sat   = ovf ? (addend[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
    flag_next = ovf || ((cnt != '0) && sat_flag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = last ? OUT : ACCUM;
      ACCUM:   if (accept && last) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != OUT) && !rst;
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_IN; i++) w[i] <= '0;
      bias     <= '0;
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (state == IDLE && cfg_we) begin
        if (cfg_addr < BIAS_ADDR) begin
          w[cfg_addr[CNT_W-1:0]] <= cfg_wdata[WEIGHT_W-1:0];
        end else if (cfg_addr == BIAS_ADDR) begin
          bias <= cfg_wdata;
        end
      end
      if (accept) begin
        acc      <= sum_sat;
        sat_flag <= flag_next;
        if (last) begin
          cnt      <= '0;
          out_data <= (relu_en && sum_sat[ACC_W-1]) ? '0 : sum_sat;
          out_sat  <= flag_next;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Bench for neuron_mac_stream: directed vectors, a vector-level reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_neuron_mac_stream;

  localparam int N_IN     = 3;
  localparam int DATA_W   = 12;
  localparam int WEIGHT_W = 12;
  localparam int ACC_W    = 26;
  localparam int ADDR_W   = 3;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [ACC_W-1:0]  cfg_wdata = '0;
  logic              relu_en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              out_sat;

  int n_checks = 0;
  int n_errors = 0;

  neuron_mac_stream #(
    .N_IN(N_IN), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vector-level bookkeeping of weights, bias and samples.
  longint mw [N_IN];
  longint vw [N_IN];
  longint samp [N_IN];
  longint mb, vb, m_res;
  bit     m_sat, m_hold, m_idle;
  int     m_n;

  function automatic void eval_vector(input bit relu);
    longint s;
    bit f;
    s = vb;
    f = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      s = s + samp[i] * vw[i];
      if (s > MAXV) begin s = MAXV; f = 1'b1; end
      else if (s < MINV) begin s = MINV; f = 1'b1; end
    end
    m_res = (relu && s < 0) ? 0 : s;
    m_sat = f;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) mw[i] = 0;
      mb = 0; m_n = 0; m_hold = 1'b0; m_res = 0; m_sat = 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else begin
      m_idle = (m_n == 0);
      if (in_valid) begin
        if (m_n == 0) begin vw = mw; vb = mb; end
        samp[m_n] = longint'($signed(in_data));
        m_n++;
        if (m_n == N_IN) begin
          eval_vector(relu_en);
          m_n = 0;
          m_hold = 1'b1;
        end
      end
      if (m_idle && cfg_we) begin
        if (int'(cfg_addr) < N_IN) mw[int'(cfg_addr)] = longint'($signed(cfg_wdata[WEIGHT_W-1:0]));
        else if (int'(cfg_addr) == N_IN) mb = longint'($signed(cfg_wdata));
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, (!rst && !m_hold) ? 1 : 0);
    check("out_valid", out_valid, m_hold ? 1 : 0);
    if (rst) check("out_data_rst", out_data, 0);
    if (m_hold) begin
      check("out_data", $signed(out_data), m_res);
      check("out_sat", out_sat, m_sat ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input longint d);
    cfg_we = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_wdata = ACC_W'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input longint x);
    int t;
    in_valid = 1'b1;
    in_data = DATA_W'(x);
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (t >= 50) check("send_timeout", 1, 0);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input longint a, input longint b, input longint c);
    send(a); send(b); send(c);
  endtask

  task automatic take(input string name, input longint exp, input longint exp_sat);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, $signed(out_data), exp);
    check({name, "_sat"}, out_sat, exp_sat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, in_ready, 1);
  endtask

  task automatic set_weights(input longint a, input longint b, input longint c, input longint bs);
    cfg_write(0, a); cfg_write(1, b); cfg_write(2, c); cfg_write(3, bs);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Basic MAC: 1000 + 2560 - 2560 + 1920
    set_weights(256, -128, 64, 1000);
    relu_en = 1'b1;
    send_vec(10, 20, 30);
    check("basic_latency", out_valid, 1);
    take("basic", 2920, 0);

    // Back-pressure with in_valid held high
    send_vec(10, 20, 30);
    in_valid = 1'b1;
    in_data = DATA_W'(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", $signed(out_data), 2920);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    send(1); send(2); send(3);
    take("bp_next", 1192, 0);

    // Weight write during ACCUM is dropped
    send(10);
    cfg_write(0, 5);
    send(20); send(30);
    take("gate_accum", 2920, 0);
    send_vec(10, 20, 30);
    take("gate_accum_next", 2920, 0);

    // Out-of-range address in IDLE is dropped
    cfg_write(4, 999);
    send_vec(10, 20, 30);
    take("gate_addr", 2920, 0);

    // Bias write coinciding with first accept takes effect on the next vector
    cfg_we = 1'b1; cfg_addr = ADDR_W'(3); cfg_wdata = '0;
    send(10);
    cfg_we = 1'b0;
    send(20); send(30);
    take("same_cycle_old", 2920, 0);
    send_vec(10, 20, 30);
    take("same_cycle_new", 1920, 0);

    // ReLU vs linear bypass
    set_weights(-256, -256, -256, 0);
    relu_en = 1'b1;
    send_vec(100, 100, 100);
    take("relu_on", 0, 0);
    relu_en = 1'b0;
    send_vec(100, 100, 100);
    take("relu_off", -76800, 0);

    // Positive and negative saturation
    set_weights(2047, 2047, 2047, 33000000);
    send_vec(2047, 2047, 2047);
    take("sat_hi", 33554431, 1);
    send_vec(1, 1, 1);
    take("sat_clear", 33006141, 0);
    set_weights(2047, 2047, 2047, -33000000);
    send_vec(-2048, -2048, -2048);
    take("sat_lo", -33554432, 1);

    // Reset mid-vector discards the partial vector and clears configuration
    set_weights(256, -128, 64, 1000);
    relu_en = 1'b0;
    send(10); send(20);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    send_vec(5, 6, 7);
    take("post_rst", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/neuron_mac_stream.md
# neuron_mac_stream

Parametrised single-neuron datapath: accepts a stream of `N_IN` signed fixed-point input samples and multiplies each by a run-time-programmable weight. It accumulates the products onto a programmable bias with saturation, then emits one activated result per input vector over a valid/ready handshake. It is the building block for layer arrays in the hardware NN datapath, replacing fixed-size, file-initialised neurons with a configurable, back-pressure-aware unit.

## Interface
- `N_IN`, 3, number of inputs (and weights) per vector; ≥1
- `DATA_W`, 12, input sample width, signed two's complement
- `WEIGHT_W`, 12, weight width, signed two's complement
- `ACC_W`, 26, accumulator/bias/output width, signed; must be ≥ `DATA_W+WEIGHT_W`
- `ADDR_W`, `$clog2(N_IN+1)`, config address width
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_we`  in  1  config write strobe
- `cfg_addr`  in  ADDR_W  0..N_IN-1 = weight index, N_IN = bias
- `cfg_wdata`  in  ACC_W  write data; weights take bits [WEIGHT_W-1:0]
- `relu_en`  in  1  1 = ReLU activation, 0 = linear bypass; sampled when the result is registered
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block can accept a sample
- `in_data`  in  DATA_W  input sample
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  ACC_W  activated result, signed
- `out_sat`  out  1  saturation occurred during this vector

## Operation
- States: IDLE (no samples of the current vector taken), ACCUM (1..N_IN-1 samples taken), OUT (result held).
- Accept = `in_valid && in_ready` at a clock edge. `in_ready` = 1 in IDLE and ACCUM, 0 in OUT and while `rst` is high.
- Sample index counter `cnt` (0..N_IN-1) selects weight `w[cnt]`. Product is the full `DATA_W+WEIGHT_W` signed value, sign-extended to ACC_W.
- On accept with cnt=0: acc ← sat(bias + product), sat flag ← overflow of that add.
- On accept with cnt>0: acc ← sat(acc + product), sat flag |= overflow.
- Saturation clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1). Overflow is detected from operand/result sign bits.
- On accept with cnt=N_IN-1: `out_data` ← (relu_en && result<0) ? 0 : result, where result is the saturated sum; `out_sat` ← final flag. `cnt` ← 0, go to OUT.
- With N_IN=1, every accept goes directly from IDLE to OUT.
- OUT: `out_valid`=1, and `out_data`/`out_sat` stay stable until `out_ready`. On `out_valid && out_ready`: go to IDLE.
- Config writes:
  - Honoured only in IDLE. In ACCUM/OUT, `cfg_we` is ignored, with no effect on weights or bias.
  - `cfg_addr` > N_IN is ignored.
  - A write and an accept in the same IDLE cycle: the accept uses the old weight/bias; the new value applies from the next cycle.
- Reset (any time, including mid-vector or in OUT): all weights and bias ← 0, acc ← 0, cnt ← 0, state ← IDLE, `out_valid` ← 0, `out_data` ← 0, `out_sat` ← 0. A partial vector is discarded.

## Timing
- Single-cycle MAC: multiply and add complete in the accept cycle, with no pipeline bubble between samples.
- The last sample is accepted at edge k, so `out_valid`=1 after edge k.
- Minimum vector period is N_IN+1 cycles, because `in_ready`=0 for at least one cycle in OUT.
- `out_valid` falls after the edge where `out_ready` is seen high. `in_ready` rises in the same cycle.
- `in_valid` gaps in ACCUM hold acc/cnt unchanged, with no timeout.
- `in_ready` and `out_valid` are derived only from state (registered). There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to any output.

## Test plan
- Basic MAC (defaults): weights 256, -128, 64, bias 1000, relu_en=1; inputs 10, 20, 30 back-to-back → out_valid one cycle after the third accept, out_data=2920, out_sat=0.
- ReLU vs bypass: weights -256 ×3, bias 0; inputs 100 ×3 → relu_en=1 gives out_data=0; relu_en=0 gives out_data=-76800.
- Saturation: bias 33000000, weights 2047 ×3; inputs 2047 ×3 → out_data=33554431, out_sat=1. Next vector with small values → out_sat=0.
- Back-pressure: hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 and out_data stable throughout. Release → one handshake, then in_ready=1 the following cycle.
- Config gating: during ACCUM, write weight 0 = 5 (ignored) → current and next vector use the old weight. In IDLE, write cfg_addr=4 (>N_IN) → no change.
- Reset mid-vector: assert rst after 2 accepts → out_valid=0 immediately and weights/bias read 0. After release, a full vector yields out_data=0.
